// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver state type and baud divider helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int clocks_per_baud(input int sysclock, input int baudrate);
    return sysclock / baudrate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to the idle-high line level
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; define UART_RX_PARITY_EN for 8E1 with o_parity_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUDRATE = 115200,
  parameter int SYSCLOCK = 100000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       o_parity_err
`endif
);

  localparam int CPB   = clocks_per_baud(SYSCLOCK, BAUDRATE);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
  logic             par_err;
`endif

  sync_2ff u_sync (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .async_in (i_uart_rx),
    .sync_out (rx_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      // A delivery later in this block overrides this clear, so ack never loses a new byte.
      if (i_ack && o_valid) o_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            cnt    <= HALF_LOAD;
            o_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (!rx_s) begin
            state   <= DATA;
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            shift   <= {rx_s, shift[7:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            par_err <= rx_s ^ (^shift);
            cnt     <= FULL_LOAD;
            state   <= STOP;
          end
        end
`endif

        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (rx_s) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_data    <= shift;
            o_valid   <= 1'b1;
            o_overrun <= o_valid && !i_ack;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= par_err;
`endif
          end else begin
            state       <= WAIT_IDLE;
            o_frame_err <= 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx at 10 clocks per bit
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 108;
`else
  localparam int LAT = 98;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic       i_ack = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
  logic       par_flip = 1'b0;
  int         pe_cnt = 0;
`endif

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         deliv_cnt = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         last_deliv_cyc = 0;
  logic       pv = 1'b0;
  logic [7:0] pd = 8'h00;
  logic [7:0] sb[$];

  uart_rx #(
    .BAUDRATE (10000000),
    .SYSCLOCK (100000000)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_uart_rx   (i_uart_rx),
    .i_ack       (i_ack),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err (o_parity_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: a delivery is a rising o_valid, an overrun pulse, or new data under o_valid.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_valid && (!pv || o_overrun || o_data !== pd)) begin
        deliv_cnt++;
        last_deliv_cyc = cyc;
        if (sb.size() == 0) check("sb_unexpected_byte", sb.size(), 1);
        else check("sb_data", o_data, sb.pop_front());
      end
      if (o_frame_err) fe_cnt++;
      if (o_overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (o_parity_err) pe_cnt++;
`endif
    end
    pv = o_valid;
    pd = o_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit push);
    if (push) sb.push_back(b);
    i_uart_rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      wait_clk(CPB);
    end
`ifdef UART_RX_PARITY_EN
    i_uart_rx = (^b) ^ par_flip;
    wait_clk(CPB);
`endif
    i_uart_rx = stop_bit;
    wait_clk(CPB);
  endtask

  task automatic wait_deliv(input int n);
    int t = 0;
    while (deliv_cnt < n && t < 400) begin
      @(negedge i_clk);
      t++;
    end
    check("deliv_count", deliv_cnt, n);
  endtask

  task automatic pulse_ack();
    i_ack = 1'b1;
    wait_clk(1);
    i_ack = 1'b0;
  endtask

  int t0, d0, f0, o0;

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_o_data", o_data, 8'h00);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_busy", o_busy, 1'b0);
    check("rst_o_frame_err", o_frame_err, 1'b0);
    check("rst_o_overrun", o_overrun, 1'b0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    wait_clk(5);

    // Good 0xA5 frame, latency and acknowledge
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_deliv(1);
    check("a5_latency_window", (last_deliv_cyc - t0 >= LAT - 8) && (last_deliv_cyc - t0 <= LAT + 2), 1'b1);
    @(negedge i_clk);
    check("a5_data", o_data, 8'hA5);
    check("a5_valid", o_valid, 1'b1);
    wait_clk(0);
    pulse_ack();
    @(negedge i_clk);
    check("a5_ack_clears_valid", o_valid, 1'b0);
    check("a5_data_kept", o_data, 8'hA5);

    // Ack with nothing pending
    wait_clk(2);
    pulse_ack();
    @(negedge i_clk);
    check("idle_ack_valid", o_valid, 1'b0);

    // Three-clock glitch is rejected
    d0 = deliv_cnt; f0 = fe_cnt;
    wait_clk(1);
    i_uart_rx = 1'b0;
    wait_clk(3);
    i_uart_rx = 1'b1;
    wait_clk(20);
    check("glitch_busy", o_busy, 1'b0);
    check("glitch_valid", o_valid, 1'b0);
    check("glitch_deliv", deliv_cnt - d0, 0);
    check("glitch_frame_err", fe_cnt - f0, 0);

    // Bad stop then a break: one frame error only
    f0 = fe_cnt; d0 = deliv_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    i_uart_rx = 1'b0;
    wait_clk(50);
    @(negedge i_clk);
    check("break_busy_held", o_busy, 1'b1);
    wait_clk(0);
    i_uart_rx = 1'b1;
    wait_clk(6);
    @(negedge i_clk);
    check("break_frame_err_count", fe_cnt - f0, 1);
    check("break_valid", o_valid, 1'b0);
    check("break_deliv", deliv_cnt - d0, 0);
    check("break_idle_after", o_busy, 1'b0);

    // Back-to-back without ack: overrun
    wait_clk(3);
    o0 = ov_cnt; d0 = deliv_cnt;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    wait_deliv(d0 + 2);
    @(negedge i_clk);
    check("ovr_data", o_data, 8'h22);
    check("ovr_valid", o_valid, 1'b1);
    check("ovr_pulse_count", ov_cnt - o0, 1);
    wait_clk(0);
    pulse_ack();

    // Back-to-back with ack coinciding with the second delivery
    wait_clk(3);
    o0 = ov_cnt; d0 = deliv_cnt;
    send_frame(8'h11, 1'b1, 1'b1);
    fork
      send_frame(8'h22, 1'b1, 1'b1);
      begin
        repeat (LAT - 1) @(posedge i_clk);
        #1 i_ack = 1'b1;
        @(posedge i_clk);
        #1 i_ack = 1'b0;
      end
    join
    wait_deliv(d0 + 2);
    wait_clk(2);
    @(negedge i_clk);
    check("coinc_data", o_data, 8'h22);
    check("coinc_valid", o_valid, 1'b1);
    check("coinc_no_overrun", ov_cnt - o0, 0);
    wait_clk(0);
    pulse_ack();

    // Reset in the middle of bit 4 of 0xFF, then a clean 0x5A
    wait_clk(3);
    d0 = deliv_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (55) @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        @(negedge i_clk);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_valid", o_valid, 1'b0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
      end
    join
    wait_clk(5);
    send_frame(8'h5A, 1'b1, 1'b1);
    wait_deliv(d0 + 1);
    wait_clk(5);
    @(negedge i_clk);
    check("midrst_only_one", deliv_cnt - d0, 1);
    check("midrst_data", o_data, 8'h5A);
    wait_clk(0);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    // Wrong parity: byte still delivered with a parity error pulse
    wait_clk(3);
    check("par_none_before", pe_cnt, 0);
    d0 = deliv_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1);
    par_flip = 1'b0;
    wait_deliv(d0 + 1);
    @(negedge i_clk);
    check("par_data", o_data, 8'h07);
    check("par_valid", o_valid, 1'b1);
    check("par_err_count", pe_cnt, 1);
    wait_clk(0);
    pulse_ack();
`endif

    wait_clk(5);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
